// File: rtl/simple_if_to_axi.sv
// Purpose: bridges a single-beat we/re memory-style request port onto an AXI4 manager port.
// Latency: 3 cycles from acceptance to mem_wdone_o/mem_rdone_o with zero-wait subordinates.
// Backpressure: busy_o high while a transaction is in flight (new requests dropped); AXI valids held until ready.

package soc_pkg;
  localparam int ADDR_W = 64;
  localparam int DATA_W = 32;
  localparam int ID_W   = 4;
  localparam int USER_W = 1;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
    logic              lock;
    logic [3:0]        cache;
    logic [2:0]        prot;
    logic [3:0]        qos;
    logic [3:0]        region;
    logic [USER_W-1:0] user;
  } m_ax_t;

  typedef struct packed {
    logic [DATA_W-1:0]   data;
    logic [DATA_W/8-1:0] strb;
    logic                last;
    logic [USER_W-1:0]   user;
  } m_w_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [1:0]        resp;
    logic [USER_W-1:0] user;
  } m_b_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
    logic [1:0]        resp;
    logic              last;
    logic [USER_W-1:0] user;
  } m_r_t;

  typedef struct packed {
    m_ax_t aw;
    logic  aw_valid;
    m_w_t  w;
    logic  w_valid;
    logic  b_ready;
    m_ax_t ar;
    logic  ar_valid;
    logic  r_ready;
  } m_req_t;

  typedef struct packed {
    logic  aw_ready;
    logic  ar_ready;
    logic  w_ready;
    logic  b_valid;
    m_b_t  b;
    logic  r_valid;
    m_r_t  r;
  } m_resp_t;
endpackage

module simple_if_to_axi #(
  parameter type         axi_req_t  = soc_pkg::m_req_t,
  parameter type         axi_resp_t = soc_pkg::m_resp_t,
  parameter logic [63:0] MEM_BASE   = 64'h0,
  parameter int          MEM_SIZE   = 32,
  parameter int unsigned AXI_ID     = 0,
  // Must equal the width of the W channel data field of axi_req_t.
  parameter int          DW         = soc_pkg::DATA_W
) (
  input  logic                clk_i,
  input  logic                arst_i,
  output axi_req_t            req_o,
  input  axi_resp_t           resp_i,
  input  logic                mem_we_i,
  input  logic [MEM_SIZE-1:0] mem_waddr_i,
  input  logic [DW-1:0]       mem_wdata_i,
  input  logic [DW/8-1:0]     mem_wstrb_i,
  output logic                mem_wdone_o,
  output logic [1:0]          mem_wresp_o,
  input  logic                mem_re_i,
  input  logic [MEM_SIZE-1:0] mem_raddr_i,
  output logic                mem_rdone_o,
  output logic [DW-1:0]       mem_rdata_o,
  output logic [1:0]          mem_rresp_o,
  output logic                busy_o
);

  localparam int AW = soc_pkg::ADDR_W;
  localparam int IW = soc_pkg::ID_W;

  typedef enum logic [2:0] {IDLE, WRITE, WRESP, READ, RDATA} state_t;

  state_t            state_q, state_d;
  logic              pending_read;
  logic              aw_done, w_done;
  logic [AW-1:0]     wr_addr, rd_addr;
  logic [DW-1:0]     wr_data;
  logic [DW/8-1:0]   wr_strb;
  logic              accept_w, accept_r;
  logic              aw_hs, w_hs, b_hs, ar_hs, r_hs;

  // Response id/user/last are not needed for single-beat, single-ID traffic.
  logic unused_resp;
  assign unused_resp = ^resp_i;

  assign busy_o   = (state_q != IDLE) | pending_read;
  assign accept_w = (state_q == IDLE) & ~busy_o & mem_we_i;
  assign accept_r = (state_q == IDLE) & ~busy_o & mem_re_i;

  // Handshake terms depend on readies only through registered state, never feeding a valid.
  assign aw_hs = (state_q == WRITE) & ~aw_done & resp_i.aw_ready;
  assign w_hs  = (state_q == WRITE) & ~w_done  & resp_i.w_ready;
  assign b_hs  = (state_q == WRESP) & resp_i.b_valid;
  assign ar_hs = (state_q == READ)  & resp_i.ar_ready;
  assign r_hs  = (state_q == RDATA) & resp_i.r_valid;

  // State register.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode and AXI request drive (valids derived only from registered state).
  always_comb begin
    state_d = state_q;
    req_o   = '0;

    req_o.aw.id    = IW'(AXI_ID);
    req_o.aw.addr  = wr_addr;
    req_o.aw.size  = 3'($clog2(DW/8));
    req_o.aw.burst = 2'b01;
    req_o.w.data   = wr_data;
    req_o.w.strb   = wr_strb;
    req_o.w.last   = 1'b1;
    req_o.ar.id    = IW'(AXI_ID);
    req_o.ar.addr  = rd_addr;
    req_o.ar.size  = 3'($clog2(DW/8));
    req_o.ar.burst = 2'b01;

    case (state_q)
      IDLE: begin
        if (accept_w)      state_d = WRITE;
        else if (accept_r) state_d = READ;
      end
      WRITE: begin
        req_o.aw_valid = ~aw_done;
        req_o.w_valid  = ~w_done;
        if ((aw_done | aw_hs) & (w_done | w_hs)) state_d = WRESP;
      end
      WRESP: begin
        req_o.b_ready = 1'b1;
        if (b_hs) state_d = pending_read ? READ : IDLE;
      end
      READ: begin
        req_o.ar_valid = 1'b1;
        if (ar_hs) state_d = RDATA;
      end
      RDATA: begin
        req_o.r_ready = 1'b1;
        if (r_hs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request capture, per-channel handshake tracking and completion reporting.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      pending_read <= 1'b0;
      aw_done      <= 1'b0;
      w_done       <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      wr_strb      <= '0;
      rd_addr      <= '0;
      mem_wdone_o  <= 1'b0;
      mem_wresp_o  <= 2'b00;
      mem_rdone_o  <= 1'b0;
      mem_rdata_o  <= '0;
      mem_rresp_o  <= 2'b00;
    end else begin
      mem_wdone_o <= 1'b0;
      mem_rdone_o <= 1'b0;

      if (accept_w) begin
        wr_addr <= MEM_BASE[AW-1:0] + AW'(mem_waddr_i);
        wr_data <= mem_wdata_i;
        wr_strb <= mem_wstrb_i;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      if (accept_r) rd_addr <= MEM_BASE[AW-1:0] + AW'(mem_raddr_i);
      // A read arriving with a write waits behind it; a lone read goes straight to READ.
      if (state_q == IDLE) pending_read <= accept_w & accept_r;

      if (aw_hs) aw_done <= 1'b1;
      if (w_hs)  w_done  <= 1'b1;

      if (b_hs) begin
        mem_wdone_o  <= 1'b1;
        mem_wresp_o  <= resp_i.b.resp;
        pending_read <= 1'b0;
      end
      if (r_hs) begin
        mem_rdone_o <= 1'b1;
        mem_rdata_o <= resp_i.r.data;
        mem_rresp_o <= resp_i.r.resp;
      end
    end
  end

endmodule

// File: tb/tb_simple_if_to_axi.sv
// Directed bench for simple_if_to_axi acting as a scripted AXI subordinate.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Transaction counters watch handshakes and done pulses for the whole run.

module tb_simple_if_to_axi;

  logic              clk_i = 1'b0;
  logic              arst_i = 1'b0;
  soc_pkg::m_req_t   req_o;
  soc_pkg::m_resp_t  resp_i;
  logic              mem_we_i, mem_re_i;
  logic [31:0]       mem_waddr_i, mem_raddr_i, mem_wdata_i;
  logic [3:0]        mem_wstrb_i;
  logic              mem_wdone_o, mem_rdone_o, busy_o;
  logic [1:0]        mem_wresp_o, mem_rresp_o;
  logic [31:0]       mem_rdata_o;

  int checks = 0;
  int failures = 0;
  int n_aw = 0, n_w = 0, n_ar = 0, n_wdone = 0, n_rdone = 0;

  localparam logic [63:0] BASE = 64'h8000_0000;

  simple_if_to_axi #(.MEM_BASE(BASE)) dut (
    .clk_i(clk_i), .arst_i(arst_i), .req_o(req_o), .resp_i(resp_i),
    .mem_we_i(mem_we_i), .mem_waddr_i(mem_waddr_i), .mem_wdata_i(mem_wdata_i),
    .mem_wstrb_i(mem_wstrb_i), .mem_wdone_o(mem_wdone_o), .mem_wresp_o(mem_wresp_o),
    .mem_re_i(mem_re_i), .mem_raddr_i(mem_raddr_i), .mem_rdone_o(mem_rdone_o),
    .mem_rdata_o(mem_rdata_o), .mem_rresp_o(mem_rresp_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    if (!arst_i) begin
      if (req_o.aw_valid && resp_i.aw_ready) n_aw++;
      if (req_o.w_valid  && resp_i.w_ready)  n_w++;
      if (req_o.ar_valid && resp_i.ar_ready) n_ar++;
      if (mem_wdone_o) n_wdone++;
      if (mem_rdone_o) n_rdone++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Write whose AW/W readies arrive aw_lat/w_lat cycles after the valids rise; B is offered early.
  task automatic write_order(input int aw_lat, input int w_lat, input logic [31:0] a,
                             input logic [31:0] d, input logic [3:0] s, input logic [1:0] br);
    int last;
    last = (aw_lat > w_lat) ? aw_lat : w_lat;
    mem_we_i = 1'b1; mem_waddr_i = a; mem_wdata_i = d; mem_wstrb_i = s;
    resp_i.b_valid = 1'b1; resp_i.b.resp = br;
    resp_i.aw_ready = 1'b0; resp_i.w_ready = 1'b0;
    tick();
    mem_we_i = 1'b0; mem_waddr_i = 32'hFFFF_FFFF; mem_wdata_i = 32'h0; mem_wstrb_i = 4'h0;
    for (int k = 0; k <= last; k++) begin
      resp_i.aw_ready = (k == aw_lat);
      resp_i.w_ready  = (k == w_lat);
      chk("ord_aw_valid", {63'd0, req_o.aw_valid}, {63'd0, k <= aw_lat});
      chk("ord_w_valid",  {63'd0, req_o.w_valid},  {63'd0, k <= w_lat});
      chk("ord_aw_addr",  req_o.aw.addr, BASE + {32'd0, a});
      chk("ord_w_data",   {32'd0, req_o.w.data}, {32'd0, d});
      chk("ord_w_strb",   {60'd0, req_o.w.strb}, {60'd0, s});
      chk("ord_b_ready_early", {63'd0, req_o.b_ready}, 64'd0);
      chk("ord_no_wdone", {63'd0, mem_wdone_o}, 64'd0);
      tick();
    end
    resp_i.aw_ready = 1'b0; resp_i.w_ready = 1'b0;
    chk("ord_b_ready", {63'd0, req_o.b_ready}, 64'd1);
    tick();
    resp_i.b_valid = 1'b0;
    chk("ord_wdone", {63'd0, mem_wdone_o}, 64'd1);
    chk("ord_wresp", {62'd0, mem_wresp_o}, {62'd0, br});
    tick();
    chk("ord_wdone_end", {63'd0, mem_wdone_o}, 64'd0);
  endtask

  initial begin
    resp_i = '0;
    mem_we_i = 1'b0; mem_re_i = 1'b0;
    mem_waddr_i = '0; mem_raddr_i = '0; mem_wdata_i = '0; mem_wstrb_i = '0;

    // Reset state.
    #1 arst_i = 1'b1;
    tick(); tick();
    chk("rst_busy", {63'd0, busy_o}, 64'd0);
    chk("rst_valids", {61'd0, req_o.aw_valid, req_o.w_valid, req_o.ar_valid}, 64'd0);
    chk("rst_readies", {62'd0, req_o.b_ready, req_o.r_ready}, 64'd0);
    chk("rst_dones", {62'd0, mem_wdone_o, mem_rdone_o}, 64'd0);
    chk("rst_rdata", {32'd0, mem_rdata_o}, 64'd0);
    arst_i = 1'b0;
    tick();

    // Zero-wait write.
    mem_we_i = 1'b1; mem_waddr_i = 32'h10; mem_wdata_i = 32'hDEAD_BEEF; mem_wstrb_i = 4'hF;
    chk("w1_busy_idle", {63'd0, busy_o}, 64'd0);
    tick();
    mem_we_i = 1'b0;
    resp_i.aw_ready = 1'b1; resp_i.w_ready = 1'b1;
    chk("w1_aw_valid", {63'd0, req_o.aw_valid}, 64'd1);
    chk("w1_w_valid", {63'd0, req_o.w_valid}, 64'd1);
    chk("w1_aw_addr", req_o.aw.addr, 64'h8000_0010);
    chk("w1_aw_len", {56'd0, req_o.aw.len}, 64'd0);
    chk("w1_aw_size", {61'd0, req_o.aw.size}, 64'd2);
    chk("w1_aw_burst", {62'd0, req_o.aw.burst}, 64'd1);
    chk("w1_aw_id", {60'd0, req_o.aw.id}, 64'd0);
    chk("w1_w_data", {32'd0, req_o.w.data}, 64'hDEAD_BEEF);
    chk("w1_w_strb", {60'd0, req_o.w.strb}, 64'hF);
    chk("w1_w_last", {63'd0, req_o.w.last}, 64'd1);
    chk("w1_busy", {63'd0, busy_o}, 64'd1);
    tick();
    resp_i.aw_ready = 1'b0; resp_i.w_ready = 1'b0;
    resp_i.b_valid = 1'b1; resp_i.b.resp = 2'b00;
    chk("w1_b_ready", {63'd0, req_o.b_ready}, 64'd1);
    chk("w1_valids_low", {62'd0, req_o.aw_valid, req_o.w_valid}, 64'd0);
    chk("w1_no_early_done", {63'd0, mem_wdone_o}, 64'd0);
    tick();
    resp_i.b_valid = 1'b0;
    chk("w1_wdone", {63'd0, mem_wdone_o}, 64'd1);
    chk("w1_wresp", {62'd0, mem_wresp_o}, 64'd0);
    chk("w1_busy_after", {63'd0, busy_o}, 64'd0);
    tick();
    chk("w1_wdone_once", {63'd0, mem_wdone_o}, 64'd0);

    // Read with 5 wait cycles and SLVERR.
    mem_re_i = 1'b1; mem_raddr_i = 32'h20;
    tick();
    mem_re_i = 1'b0; mem_raddr_i = 32'h0;
    resp_i.ar_ready = 1'b1;
    chk("r1_ar_valid", {63'd0, req_o.ar_valid}, 64'd1);
    chk("r1_ar_addr", req_o.ar.addr, 64'h8000_0020);
    chk("r1_ar_len", {56'd0, req_o.ar.len}, 64'd0);
    chk("r1_busy_ar", {63'd0, busy_o}, 64'd1);
    tick();
    resp_i.ar_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("r1_r_ready", {63'd0, req_o.r_ready}, 64'd1);
      chk("r1_busy_wait", {63'd0, busy_o}, 64'd1);
      chk("r1_no_rdone", {63'd0, mem_rdone_o}, 64'd0);
      tick();
    end
    resp_i.r_valid = 1'b1; resp_i.r.data = 32'h1234_5678; resp_i.r.resp = 2'b10; resp_i.r.last = 1'b1;
    tick();
    resp_i.r_valid = 1'b0; resp_i.r.data = 32'h0;
    chk("r1_rdone", {63'd0, mem_rdone_o}, 64'd1);
    chk("r1_rdata", {32'd0, mem_rdata_o}, 64'h1234_5678);
    chk("r1_rresp", {62'd0, mem_rresp_o}, 64'h2);
    tick();
    chk("r1_rdone_once", {63'd0, mem_rdone_o}, 64'd0);
    chk("r1_rdata_hold", {32'd0, mem_rdata_o}, 64'h1234_5678);

    // Simultaneous write and read.
    mem_we_i = 1'b1; mem_waddr_i = 32'h4; mem_wdata_i = 32'hA5A5_A5A5; mem_wstrb_i = 4'h3;
    mem_re_i = 1'b1; mem_raddr_i = 32'h8;
    tick();
    mem_we_i = 1'b0; mem_re_i = 1'b0;
    resp_i.aw_ready = 1'b1; resp_i.w_ready = 1'b1;
    chk("s_aw_addr", req_o.aw.addr, 64'h8000_0004);
    chk("s_ar_not_yet", {63'd0, req_o.ar_valid}, 64'd0);
    tick();
    resp_i.aw_ready = 1'b0; resp_i.w_ready = 1'b0;
    resp_i.b_valid = 1'b1; resp_i.b.resp = 2'b00;
    chk("s_busy_wresp", {63'd0, busy_o}, 64'd1);
    tick();
    resp_i.b_valid = 1'b0; resp_i.ar_ready = 1'b1;
    chk("s_wdone", {63'd0, mem_wdone_o}, 64'd1);
    chk("s_ar_valid", {63'd0, req_o.ar_valid}, 64'd1);
    chk("s_ar_addr", req_o.ar.addr, 64'h8000_0008);
    chk("s_busy_gap", {63'd0, busy_o}, 64'd1);
    tick();
    resp_i.ar_ready = 1'b0;
    resp_i.r_valid = 1'b1; resp_i.r.data = 32'h0BAD_F00D; resp_i.r.resp = 2'b00;
    chk("s_wdone_once", {63'd0, mem_wdone_o}, 64'd0);
    tick();
    resp_i.r_valid = 1'b0;
    chk("s_rdone", {63'd0, mem_rdone_o}, 64'd1);
    chk("s_rdata", {32'd0, mem_rdata_o}, 64'h0BAD_F00D);
    chk("s_busy_end", {63'd0, busy_o}, 64'd0);
    tick();

    // AW/W handshake orderings: W first, AW first, same cycle.
    write_order(4, 0, 32'h100, 32'h1111_2222, 4'hC, 2'b00);
    write_order(0, 4, 32'h104, 32'h3333_4444, 4'h1, 2'b11);
    write_order(2, 2, 32'h108, 32'h5555_6666, 4'hF, 2'b10);

    // Requests while busy are dropped.
    mem_re_i = 1'b1; mem_raddr_i = 32'h30;
    tick();
    mem_re_i = 1'b0;
    mem_we_i = 1'b1; mem_waddr_i = 32'h99; mem_wdata_i = 32'hFFFF_0000; mem_wstrb_i = 4'hF;
    mem_re_i = 1'b1; mem_raddr_i = 32'h9C;
    chk("b_busy", {63'd0, busy_o}, 64'd1);
    tick();
    mem_we_i = 1'b0; mem_re_i = 1'b0;
    resp_i.ar_ready = 1'b1;
    chk("b_ar_addr", req_o.ar.addr, 64'h8000_0030);
    tick();
    resp_i.ar_ready = 1'b0;
    resp_i.r_valid = 1'b1; resp_i.r.data = 32'h0000_0055; resp_i.r.resp = 2'b01;
    tick();
    resp_i.r_valid = 1'b0;
    chk("b_rdone", {63'd0, mem_rdone_o}, 64'd1);
    tick(); tick();
    chk("b_idle_valids", {61'd0, req_o.aw_valid, req_o.w_valid, req_o.ar_valid}, 64'd0);
    chk("b_idle_busy", {63'd0, busy_o}, 64'd0);
    chk("cnt_aw", n_aw, 5);
    chk("cnt_w", n_w, 5);
    chk("cnt_ar", n_ar, 3);
    chk("cnt_wdone", n_wdone, 5);
    chk("cnt_rdone", n_rdone, 3);

    // Reset during RDATA with r_valid pending.
    mem_re_i = 1'b1; mem_raddr_i = 32'h40;
    tick();
    mem_re_i = 1'b0;
    resp_i.ar_ready = 1'b1;
    tick();
    resp_i.ar_ready = 1'b0;
    resp_i.r_valid = 1'b1; resp_i.r.data = 32'hCAFE_0000; resp_i.r.resp = 2'b00;
    chk("x_r_ready", {63'd0, req_o.r_ready}, 64'd1);
    #2 arst_i = 1'b1;
    #1;
    chk("x_busy", {63'd0, busy_o}, 64'd0);
    chk("x_readies", {62'd0, req_o.b_ready, req_o.r_ready}, 64'd0);
    chk("x_valids", {61'd0, req_o.aw_valid, req_o.w_valid, req_o.ar_valid}, 64'd0);
    chk("x_rdata", {32'd0, mem_rdata_o}, 64'd0);
    chk("x_resps", {60'd0, mem_wresp_o, mem_rresp_o}, 64'd0);
    tick();
    resp_i.r_valid = 1'b0;
    arst_i = 1'b0;
    tick();
    chk("x_no_rdone", {63'd0, mem_rdone_o}, 64'd0);
    chk("x_cnt_rdone", n_rdone, 3);
    mem_re_i = 1'b1; mem_raddr_i = 32'h44;
    tick();
    mem_re_i = 1'b0;
    resp_i.ar_ready = 1'b1;
    chk("x2_ar_addr", req_o.ar.addr, 64'h8000_0044);
    tick();
    resp_i.ar_ready = 1'b0;
    resp_i.r_valid = 1'b1; resp_i.r.data = 32'h7777_1234; resp_i.r.resp = 2'b00;
    tick();
    resp_i.r_valid = 1'b0;
    chk("x2_rdone", {63'd0, mem_rdone_o}, 64'd1);
    chk("x2_rdata", {32'd0, mem_rdata_o}, 64'h7777_1234);
    chk("x2_rresp", {62'd0, mem_rresp_o}, 64'd0);
    tick();
    chk("x2_cnt_rdone", n_rdone, 4);
    chk("x2_cnt_ar", n_ar, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
